// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory controller for the single-cycle datapath.
// Holds on-chip data RAM and an input/output port pair. Every access is
// stretched by WAIT_CYCLES stall cycles to model slow memory.
module data_mem_ctrl #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_OUT_ADDR = 16'hFFFF,
    parameter logic [15:0] IO_IN_ADDR  = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Address_dm,
    input  logic [15:0] Data_dm,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic [15:0] ReadData_dm,
    output logic        stall,
    input  logic [15:0] io_in,
    output logic [15:0] io_out,
    output logic        io_out_valid,
    output logic        addr_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_WAIT   = 1'b1;
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
    localparam bit         HAS_WAIT = (WAIT_CYCLES != 0);

    logic [15:0] mem [DEPTH];

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] io_out_q, io_out_d;
    logic        io_out_valid_q, io_out_valid_d;
    logic        addr_err_q, addr_err_d;

    logic              req;
    logic              done;
    logic              mem_we;
    logic              is_ram, is_out, is_in, is_unmapped;
    logic [ADDR_W-1:0] ram_idx;

    // Address decode; RAM takes priority over the port addresses
    always_comb begin
        req         = rd_en | wr_en;
        ram_idx     = Address_dm[ADDR_W-1:0];
        is_ram      = (Address_dm >> ADDR_W) == 16'd0;
        is_out      = !is_ram && (Address_dm == IO_OUT_ADDR);
        is_in       = !is_ram && (Address_dm == IO_IN_ADDR);
        is_unmapped = !(is_ram || is_out || is_in);
    end

    // Wait-state sequencer: stall while the countdown is running
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (req) begin
            case (state_q)
                S_IDLE: begin
                    if (HAS_WAIT) begin
                        stall   = 1'b1;
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        stall = 1'b1;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            // Requester dropped the request: abandon the access
            state_d = S_IDLE;
        end
        if (!rst) begin
            stall = 1'b0;
        end
        // Reset gating keeps an in-flight access from committing
        done = rst && req && !stall;
    end

    // Completion-cycle side effects: RAM write, output port, error flag
    always_comb begin
        io_out_d       = io_out_q;
        io_out_valid_d = 1'b0;
        addr_err_d     = addr_err_q;
        mem_we         = 1'b0;
        if (done) begin
            if (is_unmapped || (wr_en && is_in)) begin
                addr_err_d = 1'b1;
            end
            if (wr_en && is_ram) begin
                mem_we = 1'b1;
            end
            if (wr_en && is_out) begin
                io_out_d       = Data_dm;
                io_out_valid_d = 1'b1;
            end
        end
    end

    // Control and port registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            io_out_q       <= 16'h0000;
            io_out_valid_q <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            io_out_q       <= io_out_d;
            io_out_valid_q <= io_out_valid_d;
            addr_err_q     <= addr_err_d;
        end
    end

    // Data RAM write port
    always_ff @(posedge clk) begin
        // NOTE: the RAM array is deliberately not reset; contents survive rst.
        if (mem_we) begin
            mem[ram_idx] <= Data_dm;
        end
    end

    // Combinational read mux toward the writeback path
    always_comb begin
        if (is_ram) begin
            ReadData_dm = mem[ram_idx];
        end else if (is_in) begin
            ReadData_dm = io_in;
        end else if (is_out) begin
            ReadData_dm = io_out_q;
        end else begin
            ReadData_dm = 16'h0000;
        end
    end

    assign io_out       = io_out_q;
    assign io_out_valid = io_out_valid_q;
    assign addr_err     = addr_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: instance 0 has two wait states, instance 1 none.
// A latency-counting reference model is compared every cycle, alongside
// directed sequences with hand-computed literal expectations.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] io_in;
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic        rd    [2];
    logic        wr    [2];
    wire  [15:0] rdata_w  [2];
    wire  [15:0] io_out_w [2];
    wire         stall_w  [2];
    wire         io_v_w   [2];
    wire         err_w    [2];

    data_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .rst(rst), .Address_dm(addr[0]), .Data_dm(wdata[0]),
        .rd_en(rd[0]), .wr_en(wr[0]), .ReadData_dm(rdata_w[0]), .stall(stall_w[0]),
        .io_in(io_in), .io_out(io_out_w[0]), .io_out_valid(io_v_w[0]), .addr_err(err_w[0])
    );

    data_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .rst(rst), .Address_dm(addr[1]), .Data_dm(wdata[1]),
        .rd_en(rd[1]), .wr_en(wr[1]), .ReadData_dm(rdata_w[1]), .stall(stall_w[1]),
        .io_in(io_in), .io_out(io_out_w[1]), .io_out_valid(io_v_w[1]), .addr_err(err_w[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an access completes once it has been requested for
    // more than wc cycles in a row; dropping the request forgets progress.
    int          wc [2] = '{2, 0};
    int          age [2];
    logic [15:0] m_mem [2][256];
    bit          m_v   [2][256];
    logic [15:0] m_io_out [2];
    bit          m_iov [2];
    bit          m_err [2];
    bit          started = 1'b0;

    function automatic bit m_req(input int i);
        return rd[i] | wr[i];
    endfunction

    function automatic bit m_stall(input int i);
        return rst && m_req(i) && (age[i] < wc[i]);
    endfunction

    function automatic bit m_done(input int i);
        return rst && m_req(i) && (age[i] >= wc[i]);
    endfunction

    always @(posedge clk) begin
        bit          dn;
        logic [15:0] a;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                age[i]      = 0;
                m_io_out[i] = 16'h0000;
                m_iov[i]    = 1'b0;
                m_err[i]    = 1'b0;
            end else begin
                dn       = m_done(i);
                a        = addr[i];
                m_iov[i] = 1'b0;
                if (dn) begin
                    age[i] = 0;
                    if (a >= 16'd256 && a != 16'hFFFF && a != 16'hFFFE) begin
                        m_err[i] = 1'b1;
                    end else if (wr[i] && a < 16'd256) begin
                        m_mem[i][a[7:0]] = wdata[i];
                        m_v[i][a[7:0]]   = 1'b1;
                    end else if (wr[i] && a == 16'hFFFF) begin
                        m_io_out[i] = wdata[i];
                        m_iov[i]    = 1'b1;
                    end else if (wr[i] && a == 16'hFFFE) begin
                        m_err[i] = 1'b1;
                    end
                end else if (m_req(i)) begin
                    age[i]++;
                end else begin
                    age[i] = 0;
                end
            end
        end
        started = 1'b1;
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [15:0] a;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                a = addr[i];
                check($sformatf("stall%0d", i), 16'(stall_w[i]), 16'(m_stall(i)));
                check($sformatf("io_out%0d", i), io_out_w[i], m_io_out[i]);
                check($sformatf("io_valid%0d", i), 16'(io_v_w[i]), 16'(m_iov[i]));
                check($sformatf("addr_err%0d", i), 16'(err_w[i]), 16'(m_err[i]));
                if (m_done(i)) begin
                    if (a < 16'd256) begin
                        if (m_v[i][a[7:0]]) begin
                            check($sformatf("rd_ram%0d", i), rdata_w[i], m_mem[i][a[7:0]]);
                        end
                    end else if (a == 16'hFFFE) begin
                        check($sformatf("rd_in%0d", i), rdata_w[i], io_in);
                    end else if (a == 16'hFFFF) begin
                        check($sformatf("rd_out%0d", i), rdata_w[i], m_io_out[i]);
                    end else begin
                        check($sformatf("rd_unmapped%0d", i), rdata_w[i], 16'h0000);
                    end
                end
            end
        end
    end

    // Hold one request until completion (bounded); report stall count and read data
    task automatic access(input int i, input logic [15:0] a, input logic [15:0] d,
                          input bit r, input bit w,
                          output logic [15:0] rv, output int ns);
        bit fin = 1'b0;
        addr[i]  = a;
        wdata[i] = d;
        rd[i]    = r;
        wr[i]    = w;
        ns       = 0;
        rv       = 16'h0000;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk);
            if (!stall_w[i]) begin
                rv  = rdata_w[i];
                fin = 1'b1;
            end else begin
                ns++;
            end
            @(posedge clk);
            #1;
        end
        check("access_completes", 16'(fin), 16'd1);
        rd[i] = 1'b0;
        wr[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] rv;
    int          ns;

    initial begin
        rst   = 1'b0;
        io_in = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            addr[i]  = 16'h0000;
            wdata[i] = 16'h0000;
            rd[i]    = 1'b0;
            wr[i]    = 1'b0;
        end
        idle(2);
        check("rst_io_out", io_out_w[0], 16'h0000);
        check("rst_io_valid", 16'(io_v_w[0]), 16'd0);
        check("rst_addr_err", 16'(err_w[0]), 16'd0);
        check("rst_stall", 16'(stall_w[0]), 16'd0);
        rst = 1'b1;
        idle(1);

        // Basic RAM write then read with two wait states
        access(0, 16'h0005, 16'h1234, 1'b0, 1'b1, rv, ns);
        check("wr_stall_cycles", 16'(ns), 16'd2);
        access(0, 16'h0005, 16'h0000, 1'b1, 1'b0, rv, ns);
        check("rd_stall_cycles", 16'(ns), 16'd2);
        check("rd_ram5", rv, 16'h1234);

        // Output port write, pulse, and input port read
        access(0, 16'hFFFF, 16'h00A5, 1'b0, 1'b1, rv, ns);
        check("io_out_after_wr", io_out_w[0], 16'h00A5);
        check("io_valid_pulse", 16'(io_v_w[0]), 16'd1);
        idle(1);
        check("io_valid_drop", 16'(io_v_w[0]), 16'd0);
        io_in = 16'hBEEF;
        access(0, 16'hFFFE, 16'h0000, 1'b1, 1'b0, rv, ns);
        check("rd_io_in", rv, 16'hBEEF);
        access(0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, rv, ns);
        check("rd_io_out", rv, 16'h00A5);
        check("no_err_yet", 16'(err_w[0]), 16'd0);

        // Unmapped access just past the RAM top
        access(0, 16'h0000, 16'h7777, 1'b0, 1'b1, rv, ns);
        access(0, 16'h0100, 16'hFFFF, 1'b0, 1'b1, rv, ns);
        check("err_set", 16'(err_w[0]), 16'd1);
        access(0, 16'h0100, 16'h0000, 1'b1, 1'b0, rv, ns);
        check("rd_unmapped", rv, 16'h0000);
        check("err_sticky", 16'(err_w[0]), 16'd1);
        access(0, 16'h0000, 16'h0000, 1'b1, 1'b0, rv, ns);
        check("mem0_intact", rv, 16'h7777);

        // Abort after one stall cycle
        access(0, 16'h0007, 16'h0707, 1'b0, 1'b1, rv, ns);
        addr[0]  = 16'h0007;
        wdata[0] = 16'h5555;
        wr[0]    = 1'b1;
        @(negedge clk);
        check("abort_stall_hi", 16'(stall_w[0]), 16'd1);
        @(posedge clk);
        #1;
        wr[0] = 1'b0;
        @(negedge clk);
        check("abort_stall_lo", 16'(stall_w[0]), 16'd0);
        @(posedge clk);
        #1;
        access(0, 16'h0007, 16'h0000, 1'b1, 1'b0, rv, ns);
        check("post_abort_stalls", 16'(ns), 16'd2);
        check("mem7_intact", rv, 16'h0707);

        // Reset during a waiting output-port write
        access(0, 16'h0020, 16'h3C3C, 1'b0, 1'b1, rv, ns);
        addr[0]  = 16'hFFFF;
        wdata[0] = 16'h9999;
        wr[0]    = 1'b1;
        @(negedge clk);
        check("rstw_stall_hi", 16'(stall_w[0]), 16'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstw_stall_forced", 16'(stall_w[0]), 16'd0);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        wr[0] = 1'b0;
        check("rstw_io_out", io_out_w[0], 16'h0000);
        check("rstw_io_valid", 16'(io_v_w[0]), 16'd0);
        check("rstw_err_clr", 16'(err_w[0]), 16'd0);
        idle(1);
        check("rstw_no_commit", io_out_w[0], 16'h0000);
        access(0, 16'h0020, 16'h0000, 1'b1, 1'b0, rv, ns);
        check("mem20_survives", rv, 16'h3C3C);
        access(0, 16'h0005, 16'h0000, 1'b1, 1'b0, rv, ns);
        check("mem5_survives", rv, 16'h1234);

        // Zero wait states: one access per cycle, back to back
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                addr[1]  = 16'(k);
                wdata[1] = 16'(16'h0010 + k);
                wr[1]    = 1'b1;
                rd[1]    = 1'b0;
            end else begin
                addr[1] = 16'(k - 4);
                wr[1]   = 1'b0;
                rd[1]   = 1'b1;
            end
            @(negedge clk);
            check("w0_stall", 16'(stall_w[1]), 16'd0);
            if (k >= 4) begin
                check("w0_rd", rdata_w[1], 16'(16'h0010 + k - 4));
            end
            @(posedge clk);
            #1;
        end
        rd[1] = 1'b0;
        wr[1] = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
